// File: rtl/vga_pixel_sink_if.sv
// Pixel-plot bus between a drawing datapath (master) and the VGA pixel sink (slave).
interface vga_pixel_sink_if;
    logic        plot;         // write strobe, one pixel per cycle
    logic [2:0]  colour;       // {R,G,B}
    logic [14:0] coordinates;  // {x[7:0], y[6:0]}
    logic        clear;        // single-cycle bulk clear request
    logic        busy;         // clear in progress, plots ignored

    modport master (output plot, colour, coordinates, clear, input busy);
    modport slave  (input plot, colour, coordinates, clear, output busy);
endinterface

// File: rtl/vga_pixel_sink.sv
// VGA pixel sink: 160x120x3 framebuffer written over the pixel-plot bus,
// bulk clear sequencer, and 640x480@60 scanout with 4x4 pixel replication.
module vga_pixel_sink #(
    parameter int         CLK_DIV      = 2,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    vga_pixel_sink_if.slave     pix,
    output logic [7:0]          o_vga_r,
    output logic [7:0]          o_vga_g,
    output logic [7:0]          o_vga_b,
    output logic                o_vga_hs,
    output logic                o_vga_vs,
    output logic                o_vga_blank_n,
    output logic                o_vga_sync_n,
    output logic                o_vga_clk
);
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FB_PIXELS = 160 * 120;

    typedef enum logic {S_IDLE, S_CLEARING} state_t;

    // ---------------- pixel tick ----------------
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    // Divider producing one pixel tick every CLK_DIV clocks.
    always_ff @(posedge i_clk) begin
        if (!i_resetn)   r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    // ---------------- scan counters ----------------
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;

    // Raster position, advanced on pixel ticks only.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_tick) begin
            if (r_hcount == 10'd799) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == 10'd524) ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    // ---------------- clear sequencer ----------------
    state_t      r_state;
    logic        r_busy;
    logic [14:0] r_clr_addr;

    // Clear FSM: walks every framebuffer address once; new requests ignored while running.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pix.clear) begin
                        r_state    <= S_CLEARING;
                        r_busy     <= 1'b1;
                        r_clr_addr <= '0;
                    end
                end
                S_CLEARING: begin
                    if (r_clr_addr == 15'(FB_PIXELS - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 15'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pix.busy = r_busy;

    // ---------------- write port ----------------
    logic [7:0]  w_x;
    logic [6:0]  w_y;
    logic        w_plot_ok;
    logic        w_clr_we;
    logic [14:0] w_plot_addr;
    logic        w_we;
    logic [14:0] w_waddr;
    logic [2:0]  w_wdata;

    assign w_x         = pix.coordinates[14:7];
    assign w_y         = pix.coordinates[6:0];
    // A clear request in the same cycle takes priority, so the plot is dropped.
    assign w_plot_ok   = pix.plot && !r_busy && !pix.clear && (w_x < 8'd160) && (w_y < 7'd120);
    assign w_plot_addr = ({8'd0, w_y} << 7) + ({8'd0, w_y} << 5) + {7'd0, w_x};
    assign w_clr_we    = (r_state == S_CLEARING);
    // Reset gates the write so an aborted clear stops at the reset edge.
    assign w_we        = i_resetn && (w_clr_we || w_plot_ok);
    assign w_waddr     = w_clr_we ? r_clr_addr : w_plot_addr;
    assign w_wdata     = w_clr_we ? CLEAR_COLOUR : pix.colour;

    // ---------------- framebuffer ----------------
    logic [2:0]  r_fb [0:FB_PIXELS-1];
    logic [2:0]  r_rdata;
    logic        w_vis;
    logic [7:0]  w_rrow;
    logic [7:0]  w_rcol;
    logic [14:0] w_raddr;

    assign w_vis   = (r_hcount < 10'd640) && (r_vcount < 10'd480);
    assign w_rrow  = r_vcount[9:2];
    assign w_rcol  = r_hcount[9:2];
    assign w_raddr = ({7'd0, w_rrow} << 7) + ({7'd0, w_rrow} << 5) + {7'd0, w_rcol};

    // Write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_we) r_fb[w_waddr] <= w_wdata;
    end

    // Scanout read port, one tick of latency; address only valid in the visible area.
    always_ff @(posedge i_clk) begin
        if (w_tick && w_vis) r_rdata <= r_fb[w_raddr];
    end

    // ---------------- video timing ----------------
    logic r_hs;
    logic r_vs;
    logic r_blank_n;

    // Syncs and blank registered on the same tick as the RAM read so all outputs align.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else if (w_tick) begin
            r_hs      <= !((r_hcount >= 10'd656) && (r_hcount < 10'd752));
            r_vs      <= !((r_vcount >= 10'd490) && (r_vcount < 10'd492));
            r_blank_n <= w_vis;
        end
    end

    assign o_vga_r       = r_blank_n ? {8{r_rdata[2]}} : 8'h00;
    assign o_vga_g       = r_blank_n ? {8{r_rdata[1]}} : 8'h00;
    assign o_vga_b       = r_blank_n ? {8{r_rdata[0]}} : 8'h00;
    assign o_vga_hs      = r_hs;
    assign o_vga_vs      = r_vs;
    assign o_vga_blank_n = r_blank_n;
    assign o_vga_sync_n  = 1'b0;
    assign o_vga_clk     = w_tick;
endmodule
